// File: rtl/irq_encoder8_if.sv
// irq_encoder8_if: request/acknowledge bundle for the 8-input priority encoder.
//   i0_n..i7_n : active-low request lines (i7_n highest priority)
//   ei_n       : active-low capture enable
//   ack        : consumer acknowledge for the presented code
//   a2..a0     : binary index of the presented request (a2 is MSB)
//   valid      : code on a2..a0 is valid
//   gs_n, eo_n : 74148-style group-select / enable-out status
//   pending    : captured, not-yet-acknowledged requests
// Modports: master = request source / code consumer, slave = the encoder.
interface irq_encoder8_if;
  logic       i0_n, i1_n, i2_n, i3_n, i4_n, i5_n, i6_n, i7_n;
  logic       ei_n;
  logic       ack;
  logic       a0, a1, a2;
  logic       valid;
  logic       gs_n;
  logic       eo_n;
  logic [7:0] pending;

  modport master (
    output i0_n, i1_n, i2_n, i3_n, i4_n, i5_n, i6_n, i7_n, ei_n, ack,
    input  a0, a1, a2, valid, gs_n, eo_n, pending
  );

  modport slave (
    input  i0_n, i1_n, i2_n, i3_n, i4_n, i5_n, i6_n, i7_n, ei_n, ack,
    output a0, a1, a2, valid, gs_n, eo_n, pending
  );
endinterface

// File: rtl/irq_encoder8.sv
// irq_encoder8: registered 8-input priority encoder with request/acknowledge handshake.
// Captures falling edges on eight active-low request lines, holds them pending and
// presents the highest pending index one at a time until acknowledged. Also drives
// 74148-style gs_n / eo_n status for cascading.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : irq_encoder8_if.slave (requests, ei_n, ack in; code, valid, status out)
// Build option: define IRQ_ENCODER8_SYNC_EN to put a 2-flop synchroniser in front of
// every request line and ei_n (adds 2 cycles to request and status latency).
module irq_encoder8 (
  input  logic            clk,
  input  logic            reset_n,
  irq_encoder8_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  // Raw inputs, active-low, ei_n in the top bit.
  logic [8:0] raw_n;
  logic [8:0] stage_in_n;

  assign raw_n = {bus.ei_n, bus.i7_n, bus.i6_n, bus.i5_n, bus.i4_n,
                  bus.i3_n, bus.i2_n, bus.i1_n, bus.i0_n};

`ifdef IRQ_ENCODER8_SYNC_EN
  // Cycles after reset until both s_q and s_d_q hold real samples.
  localparam int unsigned ArmCycles = 4;

  logic [8:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= raw_n;
      sync2_q <= sync1_q;
    end
  end

  assign stage_in_n = sync2_q;
`else
  localparam int unsigned ArmCycles = 2;

  assign stage_in_n = raw_n;
`endif

  logic [7:0] s_q, s_d_q;
  logic       se_q;
  logic [2:0] arm_cnt_q;
  logic       armed;

  // Edge detection is held off until the delay line is filled with post-reset
  // samples, so a line still held low when reset releases never looks like a rise.
  assign armed = (arm_cnt_q == 3'(ArmCycles));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q       <= '0;
      s_d_q     <= '0;
      se_q      <= 1'b0;
      arm_cnt_q <= '0;
    end else begin
      s_q   <= ~stage_in_n[7:0];
      se_q  <= ~stage_in_n[8];
      s_d_q <= s_q;
      if (!armed) begin
        arm_cnt_q <= arm_cnt_q + 3'd1;
      end
    end
  end

  logic [7:0] set_mask;

  assign set_mask = (armed && se_q) ? (s_q & ~s_d_q) : 8'h00;

  // Handshake FSM and pending register.
  state_e     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] clr_mask;
  logic [2:0] hi_idx;

  always_comb begin
    hi_idx = 3'd0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (pending_q[k]) begin
        hi_idx = 3'(k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    clr_mask = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (|pending_q) begin
          code_d  = hi_idx;
          state_d = StPresent;
        end
      end
      StPresent: begin
        // Code stays frozen here regardless of newer arrivals.
        if (bus.ack) begin
          clr_mask = 8'h01 << code_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Set after clear: a fresh rise on the acknowledged index survives.
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  logic gs_n_q, eo_n_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      code_q    <= '0;
      pending_q <= '0;
      gs_n_q    <= 1'b1;
      eo_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
      gs_n_q    <= ~(se_q & |s_q);
      eo_n_q    <= ~(se_q & ~|s_q);
    end
  end

  assign bus.a0      = code_q[0];
  assign bus.a1      = code_q[1];
  assign bus.a2      = code_q[2];
  assign bus.valid   = (state_q == StPresent);
  assign bus.gs_n    = gs_n_q;
  assign bus.eo_n    = eo_n_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_irq_encoder8.sv
module tb_irq_encoder8;

`ifdef IRQ_ENCODER8_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  irq_encoder8_if bus ();

  irq_encoder8 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] lines_n;

  // Reference model: history of sampled {se, s} vectors plus handshake state.
  logic [8:0] hist[$];
  logic [7:0] mdl_pending;
  logic       mdl_valid;
  int         mdl_code;
  logic       mdl_gs_n, mdl_eo_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] sample(input int idx);
    if (idx < hist.size()) return hist[idx];
    return 9'h000;
  endfunction

  // Highest set bit by arithmetic, not by scanning.
  function automatic int top_bit(input logic [7:0] p);
    return $clog2(int'(p) + 1) - 1;
  endfunction

  task automatic drive_lines(input logic [7:0] l);
    lines_n  = l;
    bus.i0_n = l[0];
    bus.i1_n = l[1];
    bus.i2_n = l[2];
    bus.i3_n = l[3];
    bus.i4_n = l[4];
    bus.i5_n = l[5];
    bus.i6_n = l[6];
    bus.i7_n = l[7];
  endtask

  task automatic model_reset();
    hist.delete();
    mdl_pending = 8'h00;
    mdl_valid   = 1'b0;
    mdl_code    = 0;
    mdl_gs_n    = 1'b1;
    mdl_eo_n    = 1'b1;
  endtask

  task automatic model_edge();
    logic [8:0] cur, prev;
    logic [7:0] set_m, clr_m;
    hist.push_front({~bus.ei_n, ~lines_n});
    if (hist.size() > 10) void'(hist.pop_back());
    // Value visible in the input stage just before this edge, and one edge older.
    cur  = sample(1 + Lat);
    prev = sample(2 + Lat);
    set_m = 8'h00;
    if (hist.size() > 2 + Lat && cur[8]) set_m = cur[7:0] & ~prev[7:0];
    clr_m = 8'h00;
    if (!mdl_valid) begin
      if (mdl_pending != 0) begin
        mdl_code  = top_bit(mdl_pending);
        mdl_valid = 1'b1;
      end
    end else if (bus.ack) begin
      clr_m     = 8'(1 << mdl_code);
      mdl_valid = 1'b0;
    end
    mdl_pending = (mdl_pending & ~clr_m) | set_m;
    mdl_gs_n    = !(cur[8] && cur[7:0] != 0);
    mdl_eo_n    = !(cur[8] && cur[7:0] == 0);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_pending"}, 32'(bus.pending), 32'(mdl_pending));
    check({tag, "_valid"}, 32'(bus.valid), 32'(mdl_valid));
    check({tag, "_code"}, 32'({bus.a2, bus.a1, bus.a0}), 32'(mdl_code));
    check({tag, "_gs_n"}, 32'(bus.gs_n), 32'(mdl_gs_n));
    check({tag, "_eo_n"}, 32'(bus.eo_n), 32'(mdl_eo_n));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (reset_n) model_edge();
    else model_reset();
    #1;
    check_all(tag);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !bus.valid; i++) step(tag);
    check({tag, "_wait_valid"}, 32'(bus.valid), 32'd1);
  endtask

  task automatic ack_once(input string tag);
    bus.ack = 1'b1;
    step(tag);
    bus.ack = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    drive_lines(8'hFF);
    bus.ei_n = 1'b0;
    bus.ack  = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      drive_lines(8'($urandom));
      bus.ei_n = 1'($urandom);
      bus.ack  = 1'($urandom);
      step("rst_hold");
    end
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_gs_n", 32'(bus.gs_n), 32'd1);
    check("rst_eo_n", 32'(bus.eo_n), 32'd1);

    // Release with i3_n held low: no capture.
    drive_lines(8'hF7);
    bus.ei_n = 1'b0;
    bus.ack  = 1'b0;
    release_reset();
    repeat (8) step("rst_i3");
    check("rst_i3_no_capture", 32'(bus.pending), 32'h0);
    drive_lines(8'hFF);
    repeat (4) step("idle");

    // Single request on i5.
    drive_lines(8'hDF);
    step("single");
    drive_lines(8'hFF);
    repeat (1 + Lat) step("single");
    check("single_early", 32'(bus.valid), 32'd0);
    step("single");
    check("single_valid", 32'(bus.valid), 32'd1);
    check("single_code", 32'({bus.a2, bus.a1, bus.a0}), 32'd5);
    check("single_pending", 32'(bus.pending), 32'h20);
    ack_once("single_ack");
    check("single_ack_valid", 32'(bus.valid), 32'd0);
    check("single_ack_pending", 32'(bus.pending), 32'h0);

    // Priority and hold: i1 and i6 together, then i7 while 6 is presented.
    drive_lines(8'hBD);
    wait_valid("prio");
    check("prio_first", 32'({bus.a2, bus.a1, bus.a0}), 32'd6);
    drive_lines(8'h3D);
    repeat (4) step("prio_hold");
    check("prio_hold_code", 32'({bus.a2, bus.a1, bus.a0}), 32'd6);
    check("prio_hold_pending", 32'(bus.pending), 32'hC2);
    ack_once("prio_ack6");
    check("prio_gap1", 32'(bus.valid), 32'd0);
    wait_valid("prio7");
    check("prio_second", 32'({bus.a2, bus.a1, bus.a0}), 32'd7);
    ack_once("prio_ack7");
    check("prio_gap2", 32'(bus.valid), 32'd0);
    wait_valid("prio1");
    check("prio_third", 32'({bus.a2, bus.a1, bus.a0}), 32'd1);
    ack_once("prio_ack1");
    drive_lines(8'hFF);
    repeat (4) step("idle");

    // Disable: ei_n high blocks capture and forces both status outputs high.
    bus.ei_n = 1'b1;
    repeat (Lat + 3) step("dis");
    drive_lines(8'hFB);
    step("dis");
    drive_lines(8'hFF);
    repeat (Lat + 4) step("dis");
    check("dis_pending", 32'(bus.pending), 32'h0);
    check("dis_gs_n", 32'(bus.gs_n), 32'd1);
    check("dis_eo_n", 32'(bus.eo_n), 32'd1);
    bus.ei_n = 1'b0;
    repeat (Lat + 3) step("en");
    check("en_eo_n", 32'(bus.eo_n), 32'd0);
    check("en_gs_n", 32'(bus.gs_n), 32'd1);

    // Set/clear collision on index 4.
    drive_lines(8'hEF);
    step("coll");
    drive_lines(8'hFF);
    wait_valid("coll");
    check("coll_code", 32'({bus.a2, bus.a1, bus.a0}), 32'd4);
    drive_lines(8'hEF);
    step("coll");
    drive_lines(8'hFF);
    repeat (Lat) step("coll");
    ack_once("coll_ack");
    check("coll_pending4", 32'(bus.pending[4]), 32'd1);
    check("coll_valid", 32'(bus.valid), 32'd0);
    wait_valid("coll_re");
    check("coll_recode", 32'({bus.a2, bus.a1, bus.a0}), 32'd4);
    ack_once("coll_ack2");
    check("coll_cleared", 32'(bus.pending), 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] l;
      l = lines_n;
      for (int k = 0; k < 8; k++) begin
        if (!l[k]) l[k] = ($urandom_range(0, 1) == 0);
        else       l[k] = ($urandom_range(0, 7) != 0);
      end
      drive_lines(l);
      bus.ei_n = ($urandom_range(0, 7) == 0);
      bus.ack  = mdl_valid ? 1'($urandom) : ($urandom_range(0, 9) == 0);
      step("rand");
    end

    // Drain, then reset mid-presentation with three bits pending.
    drive_lines(8'hFF);
    bus.ei_n = 1'b0;
    bus.ack  = 1'b1;
    repeat (Lat + 30) step("drain");
    bus.ack = 1'b0;
    check("drain_pending", 32'(bus.pending), 32'h0);
    drive_lines(8'h6D);
    wait_valid("midrst");
    check("midrst_pending", 32'(bus.pending), 32'h92);
    check("midrst_code", 32'({bus.a2, bus.a1, bus.a0}), 32'd7);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst_async");
    check("midrst_async_valid", 32'(bus.valid), 32'd0);
    check("midrst_async_pend", 32'(bus.pending), 32'h0);
    step("midrst_hold");
    release_reset();
    repeat (Lat + 8) step("midrst_after");
    check("midrst_no_capture", 32'(bus.pending), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
